// File: rtl/ieee_fp_pkg.sv
// Shared single-precision constants and the packed IEEE-754 word layout used by
// the fixed-to-float converter and its neighbours.
package ieee_fp_pkg;

  localparam int BIAS       = 127;
  localparam int EXP_W      = 8;
  localparam int FRAC_OUT_W = 23;
  localparam int INT_W      = 5;
  localparam int FRAC_W     = 5;

  typedef struct packed {
    logic                  sign;
    logic [EXP_W-1:0]      exp;
    logic [FRAC_OUT_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/ieee_fixed_to_float_if.sv
// Sample/result bus of the fixed-to-float converter; master is the producer,
// slave is the converter.
interface ieee_fixed_to_float_if;
  import ieee_fp_pkg::*;

  logic                  in_valid;
  logic [INT_W-1:0]      in1;
  logic [FRAC_W-1:0]     in2;
  logic                  out_valid;
  logic [31:0]           out;
  logic [FRAC_OUT_W-1:0] mantissa;
  logic [4:0]            temp;
  logic [4:0]            temp2;

  modport master (
    output in_valid, in1, in2,
    input  out_valid, out, mantissa, temp, temp2
  );

  modport slave (
    input  in_valid, in1, in2,
    output out_valid, out, mantissa, temp, temp2
  );

endinterface

// File: rtl/ieee_lod10.sv
// Combinational leading-one detector for a 10-bit word; pos is 0 when zero is set.
module ieee_lod10 (
  input  logic [9:0] v,
  output logic [3:0] pos,
  output logic       zero
);

  // NOTE: pos is given a default before the loop so every path assigns it and
  // no latch is inferred; the highest set bit is the last one to write it.
  always_comb begin
    pos = '0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) pos = 4'(i);
    end
  end

  assign zero = (v == '0);

endmodule

// File: rtl/ieee_fixed_to_float.sv
// Unsigned Q5.5 to IEEE-754 single converter, one registered stage. The result is
// exact: at most nine fraction bits survive normalisation, so no rounding exists.
module ieee_fixed_to_float #(
  parameter int INT_W  = ieee_fp_pkg::INT_W,
  parameter int FRAC_W = ieee_fp_pkg::FRAC_W,
  parameter int BIAS   = ieee_fp_pkg::BIAS
) (
  input logic                  clk,
  input logic                  rst_n,
  ieee_fixed_to_float_if.slave bus
);
  import ieee_fp_pkg::*;

  localparam int V_W = INT_W + FRAC_W;

  logic [V_W-1:0] v;
  logic [3:0]     pos;
  logic           zero;
  logic [V_W-1:0] below;
  fp32_t          nxt;
  logic [4:0]     nxt_temp;
  logic [4:0]     nxt_temp2;

  fp32_t          out_q;
  logic [4:0]     temp_q;
  logic [4:0]     temp2_q;
  logic           valid_q;

  assign v = {bus.in1, bus.in2};

  ieee_lod10 u_lod (
    .v    (v),
    .pos  (pos),
    .zero (zero)
  );

  // Shifting by (V_W - pos) drops the leading one and everything above it,
  // leaving the bits below it at the top of the field.
  always_comb begin
    below     = '0;
    nxt       = '0;
    nxt_temp  = '0;
    nxt_temp2 = '0;
    if (!zero) begin
      below     = v << (4'(V_W) - pos);
      nxt.sign  = 1'b0;
      nxt.exp   = EXP_W'(BIAS + int'(pos) - FRAC_W);
      nxt.frac  = {below, {(FRAC_OUT_W-V_W){1'b0}}};
      nxt_temp  = 5'(int'(pos) - FRAC_W);
      nxt_temp2 = 5'(pos);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      temp_q  <= '0;
      temp2_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q   <= nxt;
        temp_q  <= nxt_temp;
        temp2_q <= nxt_temp2;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.mantissa  = out_q.frac;
  assign bus.temp      = temp_q;
  assign bus.temp2     = temp2_q;

endmodule

// File: tb/tb_ieee_fixed_to_float.sv
// Self-checking bench for ieee_fixed_to_float: directed spec cases, exhaustive
// sweep and a random valid/hold stream against a real-arithmetic reference model.
module tb_ieee_fixed_to_float;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  logic [31:0] exp_out;
  logic [4:0]  exp_temp;
  logic [4:0]  exp_temp2;

  ieee_fixed_to_float_if bus ();

  ieee_fixed_to_float dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  // Reference: treat the input as a real number, let $realtobits normalise it,
  // then repack the double's exponent and top fraction bits as a single.
  function automatic int unbiased(input int v);
    real         r;
    logic [63:0] d;
    if (v == 0) return 0;
    r = real'(v) / 32.0;
    d = $realtobits(r);
    return int'(d[62:52]) - 1023;
  endfunction

  function automatic logic [31:0] ref_bits(input int v);
    real         r;
    logic [63:0] d;
    logic [7:0]  e;
    if (v == 0) return 32'h0;
    r = real'(v) / 32.0;
    d = $realtobits(r);
    e = 8'(int'(d[62:52]) - 1023 + 127);
    return {1'b0, e, d[51:29]};
  endfunction

  task automatic check_all(input string tag, input logic valid);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
    check({tag, ".out"}, bus.out, exp_out);
    check({tag, ".mant"}, 32'(bus.mantissa), 32'(exp_out[22:0]));
    check({tag, ".temp"}, 32'(bus.temp), 32'(exp_temp));
    check({tag, ".temp2"}, 32'(bus.temp2), 32'(exp_temp2));
    check({tag, ".mant_eq"}, 32'(bus.out[22:0]), 32'(bus.mantissa));
  endtask

  task automatic step(input string tag, input logic valid, input logic [4:0] a, input logic [4:0] b);
    int v;
    bus.in_valid = valid;
    bus.in1      = a;
    bus.in2      = b;
    @(posedge clk);
    #1;
    if (valid) begin
      v         = int'({a, b});
      exp_out   = ref_bits(v);
      exp_temp  = 5'(unbiased(v));
      exp_temp2 = (v == 0) ? 5'd0 : 5'(unbiased(v) + 5);
    end
    check_all(tag, valid);
  endtask

  task automatic clear_model();
    exp_out   = '0;
    exp_temp  = '0;
    exp_temp2 = '0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    clear_model();

    // Reset held with random inputs toggling
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in1      = 5'($urandom);
    bus.in2      = 5'($urandom);
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.in1 = 5'($urandom);
      bus.in2 = 5'($urandom);
      check_all("reset", 1'b0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    step("post_reset_idle", 1'b0, 5'd9, 5'd3);

    // Reference case checked against literal spec values
    step("ref", 1'b1, 5'd6, 5'd7);
    check("ref.lit_out", bus.out, 32'h40C7_0000);
    check("ref.lit_mant", 32'(bus.mantissa), 32'h0047_0000);
    check("ref.lit_temp", 32'(bus.temp), 32'd2);
    check("ref.lit_temp2", 32'(bus.temp2), 32'd7);

    // Bounds, back-to-back
    step("min", 1'b1, 5'd0, 5'd1);
    check("min.lit_out", bus.out, 32'h3D00_0000);
    check("min.lit_temp", 32'(bus.temp), 32'h1B);
    check("min.lit_temp2", 32'(bus.temp2), 32'd0);
    step("max", 1'b1, 5'd31, 5'd31);
    check("max.lit_out", bus.out, 32'h41FF_C000);
    check("max.lit_mant", 32'(bus.mantissa), 32'h007F_C000);
    check("max.lit_temp", 32'(bus.temp), 32'd4);
    check("max.lit_temp2", 32'(bus.temp2), 32'd9);
    step("one", 1'b1, 5'd1, 5'd0);
    check("one.lit_out", bus.out, 32'h3F80_0000);
    check("one.lit_temp", 32'(bus.temp), 32'd0);
    check("one.lit_temp2", 32'(bus.temp2), 32'd5);

    // Zero and hold
    step("zero_prev", 1'b1, 5'd3, 5'd17);
    step("zero", 1'b1, 5'd0, 5'd0);
    check("zero.lit_out", bus.out, 32'h0);
    step("pre_hold", 1'b1, 5'd20, 5'd11);
    step("hold1", 1'b0, 5'd0, 5'd0);
    step("hold2", 1'b0, 5'd7, 5'd7);
    check("hold.lit_out", bus.out, ref_bits(int'({5'd20, 5'd11})));

    // Asynchronous reset pulse between edges
    step("pre_async", 1'b1, 5'd13, 5'd29);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_all("async_rst", 1'b0);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    step("post_async", 1'b0, 5'd1, 5'd1);

    // Exhaustive sweep
    for (int i = 0; i < 1024; i++) begin
      step("sweep", 1'b1, 5'(i >> 5), 5'(i));
    end

    // Random stream with random gaps
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
